// File: rtl/f1_pkg.sv
// Shared types and constants for the F1 start-light lab blocks.
package f1_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEQ,
    DELAY,
    TIMING
  } ctrl_state_t;

  localparam int unsigned      LFSR_W     = 7;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 7'h01;
  // Taps for x^7 + x^6 + 1: feedback is q[6] ^ q[5].
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 7'h60;

  localparam int unsigned TICK_N_DEF = 24;

  // One Fibonacci step: shift left, feed the tap parity into bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] q);
    return {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr7.sv
// 7-bit maximal-length Fibonacci LFSR; never reaches the all-zero state.
module lfsr7
  import f1_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [LFSR_W-1:0] q
);

  // Shift register, reloaded with the seed on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= LFSR_SEED;
    end else if (en) begin
      q <= lfsr_step(q);
    end
  end

endmodule

// File: rtl/f1_start_ctrl.sv
// Start-light sequencing controller: paces the light FSM, inserts a random
// hold before lights-out and measures the driver's reaction time.
module f1_start_ctrl
  import f1_pkg::*;
#(
  parameter int unsigned TICK_N = TICK_N_DEF,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trigger_in,
  input  logic             react_btn,
  input  logic             cmd_seq,
  input  logic             cmd_delay,
  output logic             en,
  output logic             trigger_out,
  output logic             lights_rst,
  output logic             busy,
  output logic [CNT_W-1:0] react_time,
  output logic             time_valid,
  output logic             false_start
);

  localparam int unsigned       TICK_W    = $clog2(TICK_N);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_N - 1);

  ctrl_state_t       state;
  ctrl_state_t       state_nxt;

  logic              trig_q;
  logic              btn_q;
  logic              trig_edge;
  logic              btn_edge;

  logic [TICK_W-1:0] tick;
  logic              wrap;
  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] delay_cnt;
  logic              last_unit;
  logic [CNT_W-1:0]  react_cnt;

  logic              en_d;
  logic              trigger_out_d;
  logic              lights_rst_d;
  logic              time_valid_d;
  logic              false_start_d;
  logic              busy_d;

  // cmd_seq carries no decision here; it stays on the port for the light FSM handshake.
  logic              unused_cmd_seq;
  assign unused_cmd_seq = cmd_seq;

  lfsr7 u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .q   (lfsr_q)
  );

  assign trig_edge = trigger_in & ~trig_q;
  assign btn_edge  = react_btn & ~btn_q;
  assign wrap      = (tick == TICK_LAST);
  assign last_unit = (delay_cnt == LFSR_W'(1));

  // One-cycle history of the raw inputs for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trig_q <= 1'b0;
      btn_q  <= 1'b0;
    end else begin
      trig_q <= trigger_in;
      btn_q  <= react_btn;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decision; a button edge outranks every other event.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (trig_edge) state_nxt = SEQ;
      end
      SEQ: begin
        if (btn_edge)       state_nxt = IDLE;
        else if (cmd_delay) state_nxt = DELAY;
      end
      DELAY: begin
        if (btn_edge)                state_nxt = IDLE;
        else if (wrap && last_unit)  state_nxt = TIMING;
      end
      TIMING: begin
        if (btn_edge) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    en_d          = 1'b0;
    trigger_out_d = 1'b0;
    lights_rst_d  = 1'b0;
    time_valid_d  = 1'b0;
    false_start_d = 1'b0;
    unique case (state)
      IDLE: begin
        en_d          = trig_edge;
        trigger_out_d = trig_edge;
      end
      SEQ: begin
        false_start_d = btn_edge;
        lights_rst_d  = btn_edge;
        en_d          = ~btn_edge & ~cmd_delay & wrap;
      end
      DELAY: begin
        false_start_d = btn_edge;
        lights_rst_d  = btn_edge;
        en_d          = ~btn_edge & wrap & last_unit;
      end
      TIMING: begin
        time_valid_d = btn_edge;
      end
      default: ;
    endcase
    busy_d = (state_nxt != IDLE);
  end

  // Tick, delay and reaction counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick      <= '0;
      delay_cnt <= '0;
      react_cnt <= '0;
    end else begin
      if ((state == SEQ && !cmd_delay) || state == DELAY) begin
        tick <= wrap ? '0 : tick + TICK_W'(1);
      end else begin
        tick <= '0;
      end

      if (state == SEQ && cmd_delay && !btn_edge) begin
        delay_cnt <= lfsr_q;
      end else if (state == DELAY && wrap) begin
        delay_cnt <= delay_cnt - LFSR_W'(1);
      end

      // Held at zero outside TIMING so the first TIMING cycle reads 0.
      if (state == TIMING) begin
        if (react_cnt != '1) react_cnt <= react_cnt + CNT_W'(1);
      end else begin
        react_cnt <= '0;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en          <= 1'b0;
      trigger_out <= 1'b0;
      lights_rst  <= 1'b0;
      busy        <= 1'b0;
      time_valid  <= 1'b0;
      false_start <= 1'b0;
      react_time  <= '0;
    end else begin
      en          <= en_d;
      trigger_out <= trigger_out_d;
      lights_rst  <= lights_rst_d;
      busy        <= busy_d;
      time_valid  <= time_valid_d;
      false_start <= false_start_d;
      if (time_valid_d) react_time <= react_cnt;
    end
  end

endmodule

// File: doc/f1_start_ctrl.md
# f1_start_ctrl

Sequencing controller for the F1 start-light FSM. It paces the light FSM's `en` strobe, starts the sequence on a trigger edge, and inserts a pseudo-random hold before lights-out. It then measures the driver's reaction time from lights-out to button press. It sits between the board inputs (trigger button, reaction button) and the light FSM, whose `cmd_seq`/`cmd_delay` outputs it consumes.

## Interface
- `TICK_N`, default 24: cycles per light step and per delay unit; legal range ≥ 2.
- `CNT_W`, default 16: reaction counter width.
- `clk`  in  1  system clock; everything runs on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `trigger_in`  in  1  raw start request, level.
- `react_btn`  in  1  driver button, level.
- `cmd_seq`  in  1  from light FSM; high while lights are building.
- `cmd_delay`  in  1  from light FSM; high while all lights are lit (final state).
- `en`  out  1  one-cycle step strobe to the light FSM.
- `trigger_out`  out  1  one-cycle pulse to the light FSM trigger input; coincides with the first `en`.
- `lights_rst`  out  1  one-cycle synchronous reset pulse to the light FSM.
- `busy`  out  1  high in every state except IDLE.
- `react_time`  out  CNT_W  last measured reaction time, in cycles; holds its value until the next measurement.
- `time_valid`  out  1  one-cycle pulse when `react_time` updates.
- `false_start`  out  1  one-cycle pulse when the button is pressed before lights-out.

## Operation
- Edge detect: a rising edge is the input high now and low in the previous registered sample. Each of `trigger_in` and `react_btn` has its own 1-bit history register.
- LFSR: 7-bit Fibonacci, polynomial x^7+x^6+1, seed 7'h01.
  - Advances every cycle in all states and never reaches zero.
  - Sampled once, on entry to DELAY.
- States:
  - IDLE:
    - `trigger_in` edge → pulse `en` and `trigger_out` (light FSM leaves its idle state); clear tick counter; go to SEQ.
    - `react_btn` is ignored.
  - SEQ:
    - Tick counter counts 0..TICK_N-1. At TICK_N-1, pulse `en` and wrap to 0.
    - When `cmd_delay` is sampled high: load delay counter = LFSR value (1..127 units), clear tick counter, go to DELAY. No further SEQ `en` is issued.
  - DELAY:
    - Tick counter runs as in SEQ. Each wrap decrements the delay counter.
    - When the wrap occurs with delay counter = 1: pulse `en` (lights out), clear reaction counter, go to TIMING.
  - TIMING:
    - Reaction counter increments every cycle and saturates at all-ones.
    - `react_btn` edge → `react_time` ← counter value, pulse `time_valid`, go to IDLE.
- False start: a `react_btn` edge in SEQ or DELAY pulses `false_start` and `lights_rst` in the same cycle, then goes to IDLE. No `en` is issued in that cycle; `react_time` is unchanged.
- A `trigger_in` edge in any state other than IDLE is ignored.
- `en`, `trigger_out`, `lights_rst`, `time_valid` and `false_start` are never asserted for more than one cycle.

## Timing
- Reset (`rst` low, asynchronous):
  - State IDLE; LFSR 7'h01.
  - All counters, edge history registers and outputs at 0, including `react_time`.
- All outputs are registered. An input edge sampled at edge k produces its response on the output after edge k+1 (one-cycle latency).
- SEQ: `en` pulses are exactly TICK_N cycles apart. The first SEQ `en` comes TICK_N cycles after `trigger_out`.
- DELAY: lights-out `en` comes D×TICK_N cycles after DELAY entry, where D is the sampled LFSR value.
- Reaction: `react_time` = number of cycles from the lights-out `en` to the `react_btn` edge sample, minus 1. A press sampled on the cycle after `en` gives 0.
- Simultaneous events:
  - A `react_btn` edge and a tick wrap in the same cycle (SEQ/DELAY): false start wins; no `en`.
  - `cmd_delay` and a tick wrap in the same cycle (SEQ): DELAY entry wins; no `en`.
- Reset deasserted mid-sequence: the controller restarts in IDLE. It does not drive `lights_rst`; the light FSM must share the system reset.

## Structure
- Package `f1_pkg`:
  - `ctrl_state_t` enum {IDLE, SEQ, DELAY, TIMING}.
  - LFSR width, seed and tap constants.
  - Default for TICK_N.
- Sub-module `lfsr7`: clk, rst, en (tied high here), q[6:0]. Reused by other lab blocks.
- Edge detectors, tick counter, delay counter and reaction counter stay inline in `f1_start_ctrl`.

## Test plan
All scenarios use TICK_N=4.
- Reset held for 3 cycles, then released → all outputs 0, `busy`=0, LFSR output 7'h01.
- `trigger_in` rising at cycle 10 → `trigger_out`=`en`=1 at cycle 11 only; further `en` at 15, 19, 23, …; `busy`=1 from cycle 11.
- With a bench light-FSM model, `cmd_delay` rises after 8 `en` pulses → no `en` for D×4 cycles (D from the bench LFSR model), then one `en`, with `cmd_delay` falling after it.
- `react_btn` rising 37 cycles after the lights-out `en` → `time_valid` pulse, `react_time`=36, `busy`=0 on the next cycle.
- `react_btn` rising during SEQ (after the third `en`) → `false_start`=`lights_rst`=1 for one cycle, no `en`, state IDLE; a later `trigger_in` edge restarts the sequence normally.
- No `react_btn` press for 70000 cycles in TIMING → counter holds 16'hFFFF; a later press reports `react_time`=16'hFFFF. A second `trigger_in` edge mid-TIMING is ignored.
